// File: rtl/mem_stage.sv
// Memory-access pipeline stage: owns the data memory and performs byte, half-word and word
// loads and stores with a fixed wait latency, stalling upstream while an access is in flight.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              E,
  input  logic              Valid_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [31:0]       Addr,
  input  logic [DATA_W-1:0] WData,
  output logic              Stall,
  output logic              Valid_out,
  output logic [DATA_W-1:0] RData,
  output logic              Misalign
);

  // Handshake: Valid_in is taken only in IDLE on an E=1 edge; while Stall is high the
  // upstream holds its inputs and they are ignored. Valid_out pulses once per instruction.
  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] a_idx;
  logic [1:0]        a_off;
  logic [1:0]        a_size;
  logic              a_uns;
  logic              a_wr;
  logic [31:0]       a_wdata;

  logic [31:0] mem [0:(2**ADDR_W)-1];

  logic        mem_op;
  logic        misaligned;
  logic        done;
  logic        mem_we;
  logic [3:0]  a_be;
  logic [31:0] wdata_rep;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic        unused_addr;

  assign unused_addr = ^Addr[31:ADDR_W+2];
  assign Stall       = (state == WAIT);
  assign mem_op      = MemRead | MemWrite;
  assign done        = (state == WAIT) && (cnt == 4'd0);
  assign mem_we      = E && !Rst && done && a_wr;

  always_comb begin
    misaligned = 1'b0;
    case (Size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = Addr[0];
      2'b10:   misaligned = |Addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    a_be      = 4'b1111;
    wdata_rep = a_wdata;
    case (a_size)
      2'b00: begin
        a_be      = 4'b0001 << a_off;
        wdata_rep = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        a_be      = a_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{a_wdata[15:0]}};
      end
      default: begin
        a_be      = 4'b1111;
        wdata_rep = a_wdata;
      end
    endcase
  end

  always_comb begin
    rd_word  = mem[a_idx];
    rd_byte  = rd_word[{a_off, 3'b000} +: 8];
    rd_half  = a_off[1] ? rd_word[31:16] : rd_word[15:0];
    load_ext = rd_word;
    case (a_size)
      2'b00:   load_ext = a_uns ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = a_uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (a_be[b]) mem[a_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      a_idx     <= '0;
      a_off     <= 2'b00;
      a_size    <= 2'b00;
      a_uns     <= 1'b0;
      a_wr      <= 1'b0;
      a_wdata   <= 32'd0;
      Valid_out <= 1'b0;
      RData     <= '0;
      Misalign  <= 1'b0;
    end else if (!E) begin
      // Frozen: everything holds, but a completion pulse must not repeat.
      Valid_out <= 1'b0;
    end else begin
      Valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid_in) begin
            if (!mem_op) begin
              Valid_out <= 1'b1;
              RData     <= '0;
              Misalign  <= 1'b0;
            end else if (misaligned) begin
              Valid_out <= 1'b1;
              RData     <= '0;
              Misalign  <= 1'b1;
            end else begin
              a_idx   <= Addr[ADDR_W+1:2];
              a_off   <= Addr[1:0];
              a_size  <= Size;
              a_uns   <= Unsigned;
              a_wr    <= MemWrite;
              a_wdata <= WData;
              cnt     <= 4'(MEM_LAT - 1);
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= IDLE;
            Valid_out <= 1'b1;
            Misalign  <= 1'b0;
            RData     <= a_wr ? '0 : load_ext;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: drives loads/stores/faults/freezes/aborts as a linear
// sequence and compares outputs against hand-computed values with immediate assertions.
module tb_mem_stage;

  localparam int MEM_LAT = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        E;
  logic        Valid_in;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Stall;
  logic        Valid_out;
  logic [31:0] RData;
  logic        Misalign;

  int checks = 0;
  int errors = 0;

  mem_stage #(.DATA_W(32), .ADDR_W(10), .MEM_LAT(MEM_LAT)) dut (
    .Clk(Clk), .Rst(Rst), .E(E), .Valid_in(Valid_in), .MemRead(MemRead),
    .MemWrite(MemWrite), .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WData(WData),
    .Stall(Stall), .Valid_out(Valid_out), .RData(RData), .Misalign(Misalign)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    Valid_in = 1'b1; MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
    Addr = a; WData = wd;
    step();
    Valid_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Counts cycles from the current sample until Valid_out, bounded by a cycle budget.
  task automatic wait_done(output int lat, output int stalls);
    lat = 1;
    stalls = 0;
    while (!Valid_out && lat < 20) begin
      if (Stall) stalls++;
      step();
      lat++;
    end
  endtask

  task automatic op_chk(input string tag, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_mis);
    int lat, stalls;
    issue(rd, wr, sz, uns, a, wd);
    wait_done(lat, stalls);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_stall"}, stalls, exp_lat - 1);
    chk({tag, "_rdata"}, RData, exp_rd);
    chk({tag, "_mis"}, {31'b0, Misalign}, {31'b0, exp_mis});
    step();
    chk({tag, "_pulse"}, {31'b0, Valid_out}, 32'd0);
    chk({tag, "_hold"}, RData, exp_rd);
  endtask

  initial begin
    int lat, stalls;
    Rst = 1'b1; E = 1'b0; Valid_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Size = 2'b00; Unsigned = 1'b0; Addr = 32'd0; WData = 32'd0;
    step();
    step();
    Rst = 1'b0; E = 1'b1;
    step();
    chk("rst_valid", {31'b0, Valid_out}, 32'd0);
    chk("rst_rdata", RData, 32'd0);
    chk("rst_mis", {31'b0, Misalign}, 32'd0);
    chk("rst_stall", {31'b0, Stall}, 32'd0);

    // Word store then load; memory ops take MEM_LAT+1 cycles to Valid_out.
    op_chk("st_w", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0);
    op_chk("ld_w", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);

    op_chk("ld_bs", 1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 3, 32'hFFFFFFBE, 1'b0);
    op_chk("ld_bu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 3, 32'h000000BE, 1'b0);
    op_chk("ld_hs", 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 3, 32'hFFFFDEAD, 1'b0);

    // Byte store takes only the low lane of WData.
    op_chk("st_b", 1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hAABBCC55, 3, 32'h0, 1'b0);
    op_chk("ld_w2", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'h55ADBEEF, 1'b0);

    // Faults complete next cycle with no stall and no memory effect.
    op_chk("mis_h", 1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1, 32'h0, 1'b1);
    op_chk("ld_w3", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'h55ADBEEF, 1'b0);
    op_chk("mis_sw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 1, 32'h0, 1'b1);
    op_chk("mis_rsv", 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1);
    op_chk("ld_w4", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'h55ADBEEF, 1'b0);
    op_chk("nop", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b0);

    // Address wraps modulo the 4 KiB memory; unsigned half load of lanes 0-1.
    op_chk("ld_wrap", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 3, 32'h55ADBEEF, 1'b0);
    op_chk("ld_hu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 3, 32'h0000BEEF, 1'b0);

    // Store frozen by E=0 for 3 cycles mid-WAIT.
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    chk("frz_stall0", {31'b0, Stall}, 32'd1);
    E = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_stall", {30'b0, Stall, Valid_out}, 32'd2);
    end
    E = 1'b1;
    wait_done(lat, stalls);
    chk("frz_remain", lat, 32'd3);
    step();
    op_chk("ld_frz", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 32'h11223344, 1'b0);

    // Half store to upper lanes, then a read+write request acts as a byte store.
    op_chk("st_h", 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h7777BEEF, 3, 32'h0, 1'b0);
    op_chk("st_rw", 1'b1, 1'b1, 2'b00, 1'b0, 32'h21, 32'h00000099, 3, 32'h0, 1'b0);
    op_chk("ld_w5", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 32'hBEEF9944, 1'b0);

    // Reset during WAIT aborts the pending store.
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    chk("abt_stall", {31'b0, Stall}, 32'd1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("abt_idle", {30'b0, Stall, Valid_out}, 32'd0);
    step();
    chk("abt_novalid", {31'b0, Valid_out}, 32'd0);
    op_chk("ld_abt", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 32'hBEEF9944, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
